// File: rtl/de2_i2c_slave_regs.sv
// I2C target exposing a 256-entry byte register space to host logic.
// Frames are [SLAVE_ADDR+R/W, SUB_ADDR, DATA...]; SCL/SDA are oversampled on iCLK and SDA is open-drain.
`timescale 1ns/1ps
module de2_i2c_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h1A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       I2C_SCLK,
    inout  wire        I2C_SDAT,
    output logic       oWR_EN,
    output logic [7:0] oWR_ADDR,
    output logic [7:0] oWR_DATA,
    output logic [7:0] oRD_ADDR,
    input  logic [7:0] iRD_DATA,
    output logic       oACTIVE
);
    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_SUB, ST_SUB_ACK,
        ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q;
    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] tx_q, tx_d;
    logic       sda_oe_q, sda_oe_d;
    logic       active_q, active_d;
    logic       rw_q, rw_d;
    logic [7:0] ptr_q, ptr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [7:0] rx_byte;

    // Synchronizers carry no reset so a reset never fabricates bus edges.
    always_ff @(posedge iCLK) begin
        scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], I2C_SCLK};
        sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], I2C_SDAT};
        scl_prev_q <= scl_s;
        sda_prev_q <= sda_s;
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = !scl_prev_q && scl_s;
    assign scl_fall  = scl_prev_q && !scl_s;
    assign start_det = scl_prev_q && scl_s && sda_prev_q && !sda_s;
    assign stop_det  = scl_prev_q && scl_s && !sda_prev_q && sda_s;
    assign rx_byte   = {shift_q, sda_s};

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        sda_oe_d  = sda_oe_q;
        active_d  = active_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (start_det || stop_det) begin
            state_d   = start_det ? ST_ADDR : ST_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            active_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR, ST_SUB, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (state_q == ST_ADDR) begin
                                rw_d = rx_byte[0];
                                if (rx_byte[7:1] != SLAVE_ADDR) state_d = ST_IGNORE;
                            end else if (state_q == ST_SUB) begin
                                ptr_d = rx_byte;
                            end else begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = ptr_q;
                                wr_data_d = rx_byte;
                                ptr_d     = ptr_q + 8'd1;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        if (state_q == ST_ADDR) begin
                            active_d = 1'b1;
                            state_d  = ST_ADDR_ACK;
                        end else if (state_q == ST_SUB) begin
                            state_d = ST_SUB_ACK;
                        end else begin
                            state_d = ST_WDATA_ACK;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            // ACK release and read bit 7 share this edge.
                            tx_d     = {iRD_DATA[6:0], 1'b0};
                            sda_oe_d = !iRD_DATA[7];
                            state_d  = ST_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_SUB;
                        end
                    end
                end
                ST_SUB_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d  = !tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    // bit_cnt of 8 marks a received master ACK awaiting the next byte load.
                    if (scl_rise && bit_cnt_q == 4'd0) begin
                        if (!sda_s) begin
                            ptr_d     = ptr_q + 8'd1;
                            bit_cnt_d = 4'd8;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        tx_d      = {iRD_DATA[6:0], 1'b0};
                        sda_oe_d  = !iRD_DATA[7];
                        bit_cnt_d = 4'd0;
                        state_d   = ST_RDATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 7'd0;
            tx_q      <= 8'd0;
            sda_oe_q  <= 1'b0;
            active_q  <= 1'b0;
            rw_q      <= 1'b0;
            ptr_q     <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 8'd0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            sda_oe_q  <= sda_oe_d;
            active_q  <= active_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Gating with the reset lets SDA float in the very cycle reset is asserted.
    assign I2C_SDAT = (sda_oe_q && iRST_N) ? 1'b0 : 1'bz;
    assign oWR_EN   = wr_en_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oRD_ADDR = ptr_q;
    assign oACTIVE  = active_q;
endmodule

// File: tb/tb_de2_i2c_slave_regs.sv
// Bench for de2_i2c_slave_regs: a bit-banged I2C initiator plus a write scoreboard.
`timescale 1ns/1ps
module tb_de2_i2c_slave_regs;
    typedef struct {
        logic [7:0]      addr_b;
        logic [7:0]      sub_b;
        logic [3:0][7:0] data;
        int              n;
        logic            exp_ack;
        logic [7:0]      exp_ptr;
    } vec_t;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda_low = 1'b0;
    wire        sda_bus;
    logic       wr_en, active;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [7:0] host_mem [256];
    logic [15:0] exp_q [$];
    int checks = 0;
    int failures = 0;
    int slave_drv = 0;
    vec_t vecs [4];

    always #5 iCLK = ~iCLK;

    assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);
    assign rd_data = host_mem[rd_addr];

    de2_i2c_slave_regs dut (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda_bus),
        .oWR_EN   (wr_en),
        .oWR_ADDR (wr_addr),
        .oWR_DATA (wr_data),
        .oRD_ADDR (rd_addr),
        .iRD_DATA (rd_data),
        .oACTIVE  (active)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Write monitor: each oWR_EN cycle pops one expected (addr,data) pair.
    always @(negedge iCLK) begin
        if (!m_sda_low && sda_bus === 1'b0) slave_drv++;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL wr_unexpected actual=%0h/%0h required=none", wr_addr, wr_data);
            end else begin
                checkOutput("wr_addr_data", 32'({wr_addr, wr_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge iCLK);
    endtask

    task automatic i2c_start();
        m_sda_low = 1'b0; wait_clks(8);
        scl = 1'b1;       wait_clks(16);
        m_sda_low = 1'b1; wait_clks(16);
        scl = 1'b0;       wait_clks(8);
    endtask

    task automatic i2c_stop();
        m_sda_low = 1'b1; wait_clks(8);
        scl = 1'b1;       wait_clks(16);
        m_sda_low = 1'b0; wait_clks(16);
    endtask

    task automatic send_bit(input logic b);
        m_sda_low = !b; wait_clks(8);
        scl = 1'b1;     wait_clks(16);
        scl = 1'b0;     wait_clks(8);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda_low = 1'b0; wait_clks(8);
        scl = 1'b1;       wait_clks(8);
        acked = (sda_bus === 1'b0);
        wait_clks(8);
        scl = 1'b0;       wait_clks(8);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ack);
        b = 8'd0;
        for (int i = 0; i < 8; i++) begin
            m_sda_low = 1'b0; wait_clks(8);
            scl = 1'b1;       wait_clks(8);
            b = {b[6:0], (sda_bus === 1'b1)};
            wait_clks(8);
            scl = 1'b0;       wait_clks(8);
        end
        m_sda_low = ack; wait_clks(8);
        scl = 1'b1;      wait_clks(16);
        scl = 1'b0;
        m_sda_low = 1'b0; wait_clks(8);
    endtask

    function automatic vec_t make_vec(input logic [7:0] a, input logic [7:0] s,
                                      input logic [7:0] d0, input logic [7:0] d1,
                                      input logic [7:0] d2, input int n,
                                      input logic ack, input logic [7:0] ptr);
        vec_t v;
        v.addr_b  = a;
        v.sub_b   = s;
        v.data    = {8'h00, d2, d1, d0};
        v.n       = n;
        v.exp_ack = ack;
        v.exp_ptr = ptr;
        return v;
    endfunction

    // One complete write frame; expected writes are queued as each data byte is sent.
    task automatic applyStimulus(input vec_t v);
        logic acked;
        slave_drv = 0;
        i2c_start();
        send_byte(v.addr_b, acked);
        checkOutput("addr_ack", 32'(acked), 32'(v.exp_ack));
        checkOutput("active_after_addr", 32'(active), 32'(v.exp_ack));
        send_byte(v.sub_b, acked);
        checkOutput("sub_ack", 32'(acked), 32'(v.exp_ack));
        for (int i = 0; i < v.n; i++) begin
            if (v.exp_ack) exp_q.push_back({v.sub_b + 8'(i), v.data[i]});
            send_byte(v.data[i], acked);
            checkOutput("data_ack", 32'(acked), 32'(v.exp_ack));
        end
        i2c_stop();
        checkOutput("active_after_stop", 32'(active), 32'd0);
        checkOutput("rd_addr_after_frame", 32'(rd_addr), 32'(v.exp_ptr));
        checkOutput("writes_pending", 32'(exp_q.size()), 32'd0);
        if (!v.exp_ack) checkOutput("no_sda_drive", 32'(slave_drv), 32'd0);
    endtask

    initial begin
        logic       acked;
        logic [7:0] rb;

        for (int i = 0; i < 256; i++) host_mem[i] = 8'(i) ^ 8'h5A;
        host_mem[8'h10] = 8'hA5;
        host_mem[8'h11] = 8'h3C;

        vecs[0] = make_vec(8'h34, 8'h0C, 8'h5A, 8'h00, 8'h00, 1, 1'b1, 8'h0D);
        vecs[1] = make_vec(8'h34, 8'hFE, 8'h11, 8'h22, 8'h33, 3, 1'b1, 8'h01);
        vecs[2] = make_vec(8'h40, 8'h15, 8'h00, 8'h00, 8'h00, 1, 1'b0, 8'h01);
        vecs[3] = make_vec(8'h34, 8'h80, 8'hC3, 8'h3C, 8'h00, 2, 1'b1, 8'h82);

        wait_clks(6);
        @(negedge iCLK);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_active", 32'(active), 32'd0);
        checkOutput("rst_sda", 32'(sda_bus), 32'd1);
        iRST_N = 1'b1;
        wait_clks(10);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        // Pointer write, repeated START, two-byte read ended by NACK.
        i2c_start();
        send_byte(8'h34, acked);
        checkOutput("rd_wr_addr_ack", 32'(acked), 32'd1);
        send_byte(8'h10, acked);
        checkOutput("rd_sub_ack", 32'(acked), 32'd1);
        checkOutput("rd_ptr_loaded", 32'(rd_addr), 32'h10);
        i2c_start();
        send_byte(8'h35, acked);
        checkOutput("rd_addr_ack", 32'(acked), 32'd1);
        checkOutput("rd_active", 32'(active), 32'd1);
        read_byte(rb, 1'b1);
        checkOutput("rd_byte0", 32'(rb), 32'hA5);
        read_byte(rb, 1'b0);
        checkOutput("rd_byte1", 32'(rb), 32'h3C);
        checkOutput("rd_final_ptr", 32'(rd_addr), 32'h11);
        wait_clks(8);
        checkOutput("rd_sda_released", 32'(sda_bus), 32'd1);
        checkOutput("rd_active_after_nack", 32'(active), 32'd1);
        i2c_stop();
        checkOutput("rd_active_after_stop", 32'(active), 32'd0);

        // Data byte cut short by STOP after four bits.
        i2c_start();
        send_byte(8'h34, acked);
        send_byte(8'h30, acked);
        checkOutput("abort_ptr", 32'(rd_addr), 32'h30);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        wait_clks(8);
        checkOutput("abort_ptr_kept", 32'(rd_addr), 32'h30);
        applyStimulus(make_vec(8'h34, 8'h20, 8'h77, 8'h00, 8'h00, 1, 1'b1, 8'h21));

        // Reset while the address ACK holds SDA low.
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i));
        m_sda_low = 1'b0;
        wait_clks(8);
        checkOutput("ack_driven_before_reset", 32'(sda_bus), 32'd0);
        @(negedge iCLK);
        iRST_N = 1'b0;
        @(posedge iCLK);
        #1;
        checkOutput("reset_sda_released", 32'(sda_bus), 32'd1);
        checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
        checkOutput("reset_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("reset_active", 32'(active), 32'd0);
        wait_clks(3);
        iRST_N = 1'b1;
        wait_clks(8);
        applyStimulus(make_vec(8'h34, 8'h44, 8'h99, 8'h00, 8'h00, 1, 1'b1, 8'h45));

        wait_clks(10);
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/de2_i2c_slave_regs.md
Name: de2_i2c_slave_regs

Overview:
I2C responder (target) for the DE2 on-board bus. It lets an external or on-chip I2C initiator write and read a 256-entry byte register space in the FPGA. The frame format is [SLAVE_ADDR, SUB_ADDR, DATA...], the same 3-byte format the AV-config master emits. It oversamples SCL/SDA on the system clock, drives SDA open-drain, and exposes a simple write-strobe / read-address interface to host logic.

Parameters:
SLAVE_ADDR, 7'h1A, 7-bit device address; the write address byte is 8'h34, the read address byte is 8'h35.
SYNC_STAGES, 2, number of synchronizer flops on SCL and SDA; minimum 2.

Ports:
iCLK  input  1  system clock; 50 MHz in the DE2 build.
iRST_N  input  1  synchronous, active-low reset.
I2C_SCLK  input  1  I2C clock from the initiator; this block never stretches it.
I2C_SDAT  inout  1  I2C data; driven only to 0, otherwise high-Z.
oWR_EN  output  1  one-iCLK pulse per received data byte.
oWR_ADDR  output  8  register index for oWR_EN.
oWR_DATA  output  8  data byte for oWR_EN.
oRD_ADDR  output  8  current register pointer.
iRD_DATA  input  8  host data for oRD_ADDR; must be valid within 1 iCLK of a pointer change.
oACTIVE  output  1  high from an address match until STOP or re-START.

Behaviour:
- Input conditioning: SCL and SDA each pass through SYNC_STAGES flops plus one history flop. All edges are detected on the synchronized values. scl_rise = prev 0 and now 1; scl_fall = prev 1 and now 0.
- START: synchronized SDA falls while SCL is high. STOP: synchronized SDA rises while SCL is high.
- Both conditions are recognised in any state and take priority over bit handling in the same cycle.
- START: bit_cnt=0, state=ADDR, SDA released. STOP: state=IDLE, SDA released, oACTIVE=0.
- Bit sampling: the shift register captures SDA on scl_rise, MSB first. All SDA drive changes happen only on scl_fall.
- State machine: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: on the 8th bit, compare byte[7:1] with SLAVE_ADDR.
  - Mismatch: go to IGNORE, no ACK, stay until the next START or STOP.
  - Match: on the following scl_fall, drive SDA=0, set oACTIVE=1, and enter ADDR_ACK.
  - The next state is chosen by R/W: 0 gives SUB, 1 gives RDATA.
- ACK drive: SDA is held low from the scl_fall after bit 8 until the next scl_fall, then released. For RDATA, the ACK release coincides with driving bit 7.
- SUB: the 8th bit loads the pointer (oRD_ADDR) with the byte, then SUB_ACK (ACK driven), then WDATA.
- WDATA: the 8th bit is received at scl_rise. In the next cycle:
  - oWR_EN=1 for exactly 1 cycle, oWR_ADDR=pointer, oWR_DATA=byte.
  - The pointer increments modulo 256 (8'hFF wraps to 8'h00).
  - Then WDATA_ACK (ACK driven), then WDATA again.
  - Unlimited burst length.
- RDATA: on entry, and after each master ACK, the pointer is held and iRD_DATA is latched into the tx shift register at the scl_fall that starts bit 7. Each subsequent scl_fall shifts out the next bit; a 1 bit means SDA is released.
  - After 8 bits, release SDA and sample the master ACK on the next scl_rise.
  - ACK (0): pointer++ (mod 256), continue RDATA.
  - NACK (1): go to IGNORE with SDA released until STOP/START.
- Repeated START after SUB: the pointer is retained, so write-pointer-then-read works.
- Reset values: oWR_EN=0, oWR_ADDR=0, oWR_DATA=0, oRD_ADDR=0, oACTIVE=0, SDA high-Z, state=IDLE, bit_cnt=0.
- Reset asserted mid-transfer releases SDA in the same cycle. After reset, the block ignores the bus until the next START.
- START during an ACK or RDATA bit immediately releases SDA.
- No oWR_EN is produced for a data byte cut short by START/STOP (fewer than 8 bits received).

Test Plan:
- Write: START, 0x34, 0x0C, 0x5A, STOP → ACK on all 3 bytes; exactly one oWR_EN pulse with oWR_ADDR=0x0C, oWR_DATA=0x5A; oACTIVE falls at STOP.
- Burst with wrap: START, 0x34, 0xFE, 0x11, 0x22, 0x33, STOP → writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33); oRD_ADDR=0x01 afterwards.
- Address mismatch: START, 0x40, 0x15, 0x00, STOP → SDA never driven; no oWR_EN; oACTIVE stays 0.
- Read after repeated START: START, 0x34, 0x10, rSTART, 0x35, then master ACK, master NACK; host returns iRD_DATA = 0xA5 at addr 0x10 and 0x3C at addr 0x11 → SDA carries 0xA5 then 0x3C; final oRD_ADDR=0x11; SDA released after NACK.
- Abort: STOP after 4 data bits of a write, then START, 0x34, 0x20, 0x77, STOP → no write for the partial byte; a single write (0x20, 0x77).
- Reset mid-ACK: assert iRST_N=0 while SDA is driven low → SDA high-Z on the next iCLK; all outputs at reset values; the next full write frame is accepted.
